// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared timing constants and helpers for the VGA timing generator.
//   - axis_timing_t : visible/front/sync/back widths for one axis
//   - VGA640_*      : 640x480@60 (800x525 totals)
//   - VGA800_*      : 800x600@60 (1056x628 totals)
//   - axis_total()  : LINE / FRAME derivation
//   - PIPE_DELAY_MAX: deepest supported sync/visible delay line
package vga_timing_pkg;

  localparam int PIPE_DELAY_MAX = 15;

  typedef struct packed {
    int visible;
    int front;
    int sync;
    int back;
  } axis_timing_t;

  localparam axis_timing_t VGA640_H = '{visible: 640, front: 16, sync: 96,  back: 48};
  localparam axis_timing_t VGA640_V = '{visible: 480, front: 10, sync: 2,   back: 33};
  localparam axis_timing_t VGA800_H = '{visible: 800, front: 40, sync: 128, back: 88};
  localparam axis_timing_t VGA800_V = '{visible: 600, front: 1,  sync: 4,   back: 23};

  // Total period of one axis (LINE for horizontal, FRAME for vertical).
  function automatic int axis_total(input int visible, input int front,
                                    input int sync, input int back);
    return visible + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line
//   WIDTH-bit shift register advancing only when enable is high.
//   DEPTH=0 is a combinational passthrough. Reset loads RESET_VALUE
//   into every stage so the output never shows stale data after reset.
// Ports:
//   clock  : system clock
//   reset  : synchronous active-high reset
//   enable : shift strobe
//   din    : input bundle
//   dout   : bundle delayed by DEPTH enables
module vga_delay_line #(
  parameter int               WIDTH       = 1,
  parameter int               DEPTH       = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ctrl;
      assign unused_ctrl = ^{clock, reset, enable};
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_reg [DEPTH];

      always_ff @(posedge clock) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) stage_reg[i] <= RESET_VALUE;
        end else if (enable) begin
          stage_reg[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
        end
      end

      assign dout = stage_reg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   VGA raster timing: hcount/vcount counters advancing on pixelClock,
//   hsync/vsync/visible decode (optionally delayed PIPE_DELAY pixel
//   enables to match a pipelined pixel datapath) and one-clock
//   lineStart/frameStart strobes.
//   Optional: define VGA_TIMING_FRAME_COUNT_EN to add a 16-bit frameCount.
// Ports:
//   clock      : system clock, posedge
//   reset      : synchronous active-high reset
//   pixelClock : pixel enable
//   hcount     : column 0..LINE-1 (never delayed)
//   vcount     : row 0..FRAME-1 (never delayed)
//   hsync      : horizontal sync, delayed PIPE_DELAY pixels
//   vsync      : vertical sync, delayed PIPE_DELAY pixels
//   visible    : active-video flag, delayed PIPE_DELAY pixels
//   lineStart  : one-clock strobe when hcount wraps to 0
//   frameStart : one-clock strobe when hcount and vcount both wrap to 0
//   frameCount : (VGA_TIMING_FRAME_COUNT_EN only) frames since reset
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   WIDTH      = 12,
  parameter int   H_VISIBLE  = 640,
  parameter int   H_FRONT    = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BACK     = 48,
  parameter int   V_VISIBLE  = 480,
  parameter int   V_FRONT    = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BACK     = 33,
  parameter logic H_PULSE    = 1'b0,
  parameter logic V_PULSE    = 1'b0,
  parameter int   PIPE_DELAY = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pixelClock,
  output logic [WIDTH-1:0] hcount,
  output logic [WIDTH-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             visible,
  output logic             lineStart,
  output logic             frameStart
`ifdef VGA_TIMING_FRAME_COUNT_EN
  ,
  output logic [15:0]      frameCount
`endif
);

  localparam int LINE  = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int FRAME = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  generate
    if (LINE >= 2**WIDTH) begin : g_line_too_wide
      $error("vga_timing_gen: LINE does not fit in WIDTH bits");
    end
    if (FRAME >= 2**WIDTH) begin : g_frame_too_wide
      $error("vga_timing_gen: FRAME does not fit in WIDTH bits");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > PIPE_DELAY_MAX) begin : g_bad_delay
      $error("vga_timing_gen: PIPE_DELAY out of range");
    end
  endgenerate

  localparam logic [WIDTH-1:0] H_LAST       = WIDTH'(LINE - 1);
  localparam logic [WIDTH-1:0] V_LAST       = WIDTH'(FRAME - 1);
  localparam logic [WIDTH-1:0] H_VIS_END    = WIDTH'(H_VISIBLE);
  localparam logic [WIDTH-1:0] V_VIS_END    = WIDTH'(V_VISIBLE);
  localparam logic [WIDTH-1:0] H_SYNC_START = WIDTH'(H_VISIBLE + H_FRONT);
  localparam logic [WIDTH-1:0] H_SYNC_END   = WIDTH'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [WIDTH-1:0] V_SYNC_START = WIDTH'(V_VISIBLE + V_FRONT);
  localparam logic [WIDTH-1:0] V_SYNC_END   = WIDTH'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [WIDTH-1:0] hcount_reg;
  logic [WIDTH-1:0] vcount_reg;
  logic             line_start_reg;
  logic             frame_start_reg;
  logic             h_wrap;
  logic             v_wrap;

  assign h_wrap = (hcount_reg == H_LAST);
  assign v_wrap = (vcount_reg == V_LAST);

  // Strobes are recomputed every clock, so they fall after one cycle even
  // when pixelClock stays high; a reset-induced return to 0 never strobes.
  always_ff @(posedge clock) begin
    if (reset) begin
      hcount_reg      <= '0;
      vcount_reg      <= '0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      line_start_reg  <= pixelClock && h_wrap;
      frame_start_reg <= pixelClock && h_wrap && v_wrap;
      if (pixelClock) begin
        hcount_reg <= h_wrap ? '0 : hcount_reg + 1'b1;
        if (h_wrap) vcount_reg <= v_wrap ? '0 : vcount_reg + 1'b1;
      end
    end
  end

  logic hs_raw;
  logic vs_raw;
  logic vis_raw;

  always_comb begin
    hs_raw  = ((hcount_reg >= H_SYNC_START) && (hcount_reg < H_SYNC_END)) ? H_PULSE : ~H_PULSE;
    vs_raw  = ((vcount_reg >= V_SYNC_START) && (vcount_reg < V_SYNC_END)) ? V_PULSE : ~V_PULSE;
    vis_raw = (hcount_reg < H_VIS_END) && (vcount_reg < V_VIS_END);
  end

  logic [2:0] sync_bundle;

  vga_delay_line #(
    .WIDTH      (3),
    .DEPTH      (PIPE_DELAY),
    .RESET_VALUE({~H_PULSE, ~V_PULSE, 1'b0})
  ) u_sync_delay (
    .clock (clock),
    .reset (reset),
    .enable(pixelClock),
    .din   ({hs_raw, vs_raw, vis_raw}),
    .dout  (sync_bundle)
  );

  assign hcount     = hcount_reg;
  assign vcount     = vcount_reg;
  assign hsync      = sync_bundle[2];
  assign vsync      = sync_bundle[1];
  assign visible    = sync_bundle[0];
  assign lineStart  = line_start_reg;
  assign frameStart = frame_start_reg;

`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [15:0] frame_count_reg;

  // Bumps on the same edge that raises frameStart; wraps naturally at 16 bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_count_reg <= '0;
    end else if (pixelClock && h_wrap && v_wrap) begin
      frame_count_reg <= frame_count_reg + 16'd1;
    end
  end

  assign frameCount = frame_count_reg;
`endif

endmodule
